// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline boundary: two-entry elastic buffer toward MEM, branch/jump
// resolution with a one-cycle fetch redirect, and branch performance counters.
module ex_mem_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_c,
  input  logic        ex_zero,
  input  logic        ex_sign,
  input  logic        ex_overflow,
  input  logic        ex_carry,
  input  logic [4:0]  ex_aluop,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_result,
  output logic [31:0] mem_rs2_data,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_write,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_total_cnt,
  output logic [31:0] br_taken_cnt
);

  // Branch ALUOp encodings; these mirror the core's ALUOp definitions.
  localparam logic [4:0] ALU_BEQ  = 5'd10;
  localparam logic [4:0] ALU_BNE  = 5'd11;
  localparam logic [4:0] ALU_BLT  = 5'd12;
  localparam logic [4:0] ALU_BGE  = 5'd13;
  localparam logic [4:0] ALU_BLTU = 5'd14;
  localparam logic [4:0] ALU_BGEU = 5'd15;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } beat_t;

  beat_t       main_q, skid_q, beat_in, main_n, skid_n;
  logic        main_full, skid_full, main_full_n, skid_full_n;
  logic        br_cond, xfer_taken, discard, accept, store, pop;
  logic [31:0] target;
  logic [31:0] br_total_q, br_taken_q;

  // Branch condition, target and link selection for the offered beat.
  always_comb begin
    br_cond = 1'b0;
    case (ex_aluop)
      ALU_BEQ:  br_cond = ex_zero;
      ALU_BNE:  br_cond = !ex_zero;
      ALU_BLT:  br_cond = ex_sign ^ ex_overflow;
      ALU_BGE:  br_cond = !(ex_sign ^ ex_overflow);
      ALU_BLTU: br_cond = ex_carry;
      ALU_BGEU: br_cond = !ex_carry;
      default:  br_cond = 1'b0;
    endcase
    xfer_taken = (ex_is_branch && br_cond) || ex_is_jal || ex_is_jalr;
    target     = ex_is_jalr ? (ex_alu_c & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
    beat_in.result    = (ex_is_jal || ex_is_jalr) ? (ex_pc + 32'd4) : ex_alu_c;
    beat_in.rs2_data  = ex_rs2_data;
    beat_in.rd        = ex_rd;
    beat_in.reg_write = ex_reg_write;
    beat_in.mem_read  = ex_mem_read;
    beat_in.mem_write = ex_mem_write;
  end

  // Ready comes only from registered state; the beat after a redirect is wrong-path.
  assign ex_ready = !skid_full || redirect_valid;
  assign discard  = redirect_valid || flush;
  assign accept   = ex_valid && ex_ready;
  assign store    = accept && !discard;
  assign pop      = main_full && mem_ready;

  // Buffer next state: pop refills main from skid, then the new beat takes the
  // first free slot so ordering is preserved. Flush wins over everything.
  always_comb begin
    main_n      = main_q;
    skid_n      = skid_q;
    main_full_n = main_full;
    skid_full_n = skid_full;
    if (pop) begin
      if (skid_full) begin
        main_n      = skid_q;
        main_full_n = 1'b1;
        skid_full_n = 1'b0;
      end else begin
        main_full_n = 1'b0;
      end
    end
    if (store) begin
      if (!main_full_n) begin
        main_n      = beat_in;
        main_full_n = 1'b1;
      end else begin
        skid_n      = beat_in;
        skid_full_n = 1'b1;
      end
    end
    if (flush) begin
      main_full_n = 1'b0;
      skid_full_n = 1'b0;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_q    <= '0;
      skid_q    <= '0;
      main_full <= 1'b0;
      skid_full <= 1'b0;
    end else begin
      main_q    <= main_n;
      skid_q    <= skid_n;
      main_full <= main_full_n;
      skid_full <= skid_full_n;
    end
  end

  // One-cycle redirect pulse for every stored taken transfer (store excludes flush).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= store && xfer_taken;
      if (store && xfer_taken) redirect_pc <= target;
    end
  end

  // Branch performance counters; free-running wrap, untouched by flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      br_total_q <= '0;
      br_taken_q <= '0;
    end else if (store && ex_is_branch) begin
      br_total_q <= br_total_q + 32'd1;
      if (br_cond) br_taken_q <= br_taken_q + 32'd1;
    end
  end

  assign br_total_cnt  = br_total_q;
  assign br_taken_cnt  = br_taken_q;
  assign mem_valid     = main_full;
  assign mem_result    = main_q.result;
  assign mem_rs2_data  = main_q.rs2_data;
  assign mem_rd        = main_q.rd;
  assign mem_reg_write = main_q.reg_write;
  assign mem_mem_read  = main_q.mem_read;
  assign mem_mem_write = main_q.mem_write;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: expected MEM beats are queued when a beat
// is stored and compared when the stage pops it.
module tb_ex_mem_stage;

  localparam logic [4:0] ALU_ADD  = 5'd3;
  localparam logic [4:0] ALU_BEQ  = 5'd10;
  localparam logic [4:0] ALU_BNE  = 5'd11;
  localparam logic [4:0] ALU_BLT  = 5'd12;
  localparam logic [4:0] ALU_BGE  = 5'd13;
  localparam logic [4:0] ALU_BLTU = 5'd14;
  localparam logic [4:0] ALU_BGEU = 5'd15;

  logic clk = 1'b0, rstn, flush, ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_alu_c, ex_imm, ex_rs2_data;
  logic ex_zero, ex_sign, ex_overflow, ex_carry;
  logic [4:0] ex_aluop, ex_rd;
  logic ex_is_branch, ex_is_jal, ex_is_jalr, ex_reg_write, ex_mem_read, ex_mem_write;
  logic mem_valid, mem_ready;
  logic [31:0] mem_result, mem_rs2_data;
  logic [4:0] mem_rd;
  logic mem_reg_write, mem_mem_read, mem_mem_write, redirect_valid;
  logic [31:0] redirect_pc, br_total_cnt, br_taken_cnt;

  ex_mem_stage dut (
    .clk(clk), .rstn(rstn), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_alu_c(ex_alu_c), .ex_zero(ex_zero), .ex_sign(ex_sign),
    .ex_overflow(ex_overflow), .ex_carry(ex_carry), .ex_aluop(ex_aluop),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_imm(ex_imm), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result),
    .mem_rs2_data(mem_rs2_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_total_cnt(br_total_cnt), .br_taken_cnt(br_taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  ctl;
  } exp_t;

  exp_t        sb_q[$];
  logic        m_redir;
  logic [31:0] m_tot, m_tak;
  int          checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit br_taken(input logic [4:0] op, input logic z, s, o, c);
    case (op)
      ALU_BEQ:  return z;
      ALU_BNE:  return !z;
      ALU_BLT:  return s ^ o;
      ALU_BGE:  return !(s ^ o);
      ALU_BLTU: return c;
      ALU_BGEU: return !c;
      default:  return 1'b0;
    endcase
  endfunction

  // One clock: check pre-edge outputs against the model, advance the model,
  // then check the registered redirect and counters just after the edge.
  task automatic tick(output bit acc);
    bit exp_rdy, st, tk, nxt_redir;
    logic [31:0] nxt_pc;
    exp_t e;
    exp_rdy = (sb_q.size() < 2) || m_redir;
    check("ex_ready", {31'd0, ex_ready}, {31'd0, exp_rdy});
    check("mem_valid", {31'd0, mem_valid}, {31'd0, sb_q.size() > 0});
    if (sb_q.size() > 0 && mem_ready) begin
      e = sb_q.pop_front();
      check("mem_result", mem_result, e.res);
      check("mem_rs2_data", mem_rs2_data, e.rs2);
      check("mem_rd", {27'd0, mem_rd}, {27'd0, e.rd});
      check("mem_ctl", {29'd0, mem_reg_write, mem_mem_read, mem_mem_write}, {29'd0, e.ctl});
    end
    acc = ex_valid && exp_rdy;
    st  = acc && !m_redir && !flush;
    tk  = ex_is_branch && br_taken(ex_aluop, ex_zero, ex_sign, ex_overflow, ex_carry);
    nxt_redir = 1'b0;
    nxt_pc    = '0;
    if (st) begin
      e.res = (ex_is_jal || ex_is_jalr) ? ex_pc + 32'd4 : ex_alu_c;
      e.rs2 = ex_rs2_data;
      e.rd  = ex_rd;
      e.ctl = {ex_reg_write, ex_mem_read, ex_mem_write};
      sb_q.push_back(e);
      if (ex_is_branch) begin
        m_tot = m_tot + 32'd1;
        if (tk) m_tak = m_tak + 32'd1;
      end
      nxt_redir = tk || ex_is_jal || ex_is_jalr;
      nxt_pc    = ex_is_jalr ? {ex_alu_c[31:1], 1'b0} : ex_pc + ex_imm;
    end
    if (flush) sb_q.delete();
    @(posedge clk);
    #1;
    m_redir = nxt_redir;
    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, nxt_redir});
    if (nxt_redir) check("redirect_pc", redirect_pc, nxt_pc);
    check("br_total_cnt", br_total_cnt, m_tot);
    check("br_taken_cnt", br_taken_cnt, m_tak);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  // cls = {branch, jal, jalr}; flg = {zero, sign, overflow, carry}
  task automatic set_beat(input logic [31:0] pc, c, input logic [4:0] op,
                          input logic [2:0] cls, input logic [31:0] imm,
                          input logic [4:0] rd, input logic [3:0] flg);
    ex_valid = 1'b1;
    ex_pc = pc; ex_alu_c = c; ex_aluop = op; ex_imm = imm; ex_rd = rd;
    {ex_is_branch, ex_is_jal, ex_is_jalr} = cls;
    {ex_zero, ex_sign, ex_overflow, ex_carry} = flg;
    ex_rs2_data = pc ^ 32'h0000_A5A5;
    ex_reg_write = 1'b1; ex_mem_read = rd[1]; ex_mem_write = rd[0];
  endtask

  task automatic send(input logic [31:0] pc, c, input logic [4:0] op,
                      input logic [2:0] cls, input logic [31:0] imm,
                      input logic [4:0] rd, input logic [3:0] flg);
    bit a;
    int n;
    set_beat(pc, c, op, cls, imm, rd, flg);
    a = 1'b0;
    n = 0;
    while (!a && n < 16) begin
      tick(a);
      n++;
    end
    if (!a) check("accept_timeout", 32'd0, 32'd1);
    ex_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    rstn = 1'b0; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
    set_beat(32'd0, 32'd0, ALU_ADD, 3'b000, 32'd0, 5'd0, 4'd0);
    ex_valid = 1'b0;
    m_redir = 1'b0; m_tot = '0; m_tak = '0;
    #12;
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    check("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    check("rst_total", br_total_cnt, 32'd0);
    check("rst_taken", br_taken_cnt, 32'd0);
    check("rst_mem_result", mem_result, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // first beat and latency
    send(32'h10, 32'h5, ALU_ADD, 3'b000, 32'd0, 5'd3, 4'd0);
    idle(2);

    // back-to-back throughput
    send(32'h14, 32'h11, ALU_ADD, 3'b000, 32'd0, 5'd4, 4'd0);
    send(32'h18, 32'h12, ALU_ADD, 3'b000, 32'd0, 5'd5, 4'd0);
    idle(2);

    // backpressure: A, B absorbed, C waits until MEM drains
    mem_ready = 1'b0;
    send(32'h20, 32'hA, ALU_ADD, 3'b000, 32'd0, 5'd6, 4'd0);
    send(32'h24, 32'hB, ALU_ADD, 3'b000, 32'd0, 5'd7, 4'd0);
    set_beat(32'h28, 32'hC, ALU_ADD, 3'b000, 32'd0, 5'd9, 4'd0);
    tick(a);
    tick(a);
    mem_ready = 1'b1;
    send(32'h28, 32'hC, ALU_ADD, 3'b000, 32'd0, 5'd9, 4'd0);
    idle(3);

    // branch flags
    send(32'h100, 32'h0, ALU_BLT, 3'b100, 32'h20, 5'd0, 4'b0100);
    idle(2);
    send(32'h104, 32'h0, ALU_BGEU, 3'b100, 32'h40, 5'd0, 4'b0001);
    idle(1);
    send(32'h108, 32'h0, ALU_BEQ, 3'b100, 32'h8, 5'd0, 4'b1000);
    idle(1);
    send(32'h10C, 32'h0, ALU_BGE, 3'b100, 32'h8, 5'd0, 4'b0110);
    idle(1);
    send(32'h110, 32'h0, ALU_BLTU, 3'b100, 32'h8, 5'd0, 4'b0000);
    idle(1);
    send(32'h114, 32'h0, ALU_ADD, 3'b100, 32'h8, 5'd0, 4'b1111);
    idle(2);

    // jalr redirect; the following beat is wrong-path and discarded
    send(32'h40, 32'h2003, ALU_ADD, 3'b001, 32'd0, 5'd1, 4'd0);
    send(32'h44, 32'h77, ALU_ADD, 3'b000, 32'd0, 5'd2, 4'd0);
    idle(3);

    // flush with both entries full and a taken branch offered
    mem_ready = 1'b0;
    send(32'h50, 32'h1, ALU_ADD, 3'b000, 32'd0, 5'd8, 4'd0);
    send(32'h54, 32'h2, ALU_ADD, 3'b000, 32'd0, 5'd10, 4'd0);
    set_beat(32'h58, 32'h0, ALU_BEQ, 3'b100, 32'h10, 5'd0, 4'b1000);
    flush = 1'b1;
    tick(a);
    flush = 1'b0;
    ex_valid = 1'b0;
    mem_ready = 1'b1;
    idle(2);

    // flush against an accepted jal on an empty stage: no redirect, not stored
    set_beat(32'h60, 32'h0, ALU_ADD, 3'b010, 32'h100, 5'd11, 4'd0);
    flush = 1'b1;
    tick(a);
    flush = 1'b0;
    ex_valid = 1'b0;
    idle(2);

    // counter wrap and link wrap
    force dut.br_total_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_total_q;
    m_tot = 32'hFFFF_FFFF;
    send(32'h70, 32'h0, ALU_BNE, 3'b100, 32'h10, 5'd0, 4'b0000);
    idle(2);
    send(32'hFFFF_FFFC, 32'h0, ALU_ADD, 3'b010, 32'h8, 5'd12, 4'd0);
    idle(3);

    // asynchronous reset mid-operation drops buffered beats
    mem_ready = 1'b0;
    send(32'h80, 32'h3, ALU_ADD, 3'b000, 32'd0, 5'd13, 4'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("async_rst_total", br_total_cnt, 32'd0);
    sb_q.delete();
    m_redir = 1'b0; m_tot = '0; m_tak = '0;
    @(negedge clk);
    rstn = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    send(32'h90, 32'h9, ALU_ADD, 3'b000, 32'd0, 5'd14, 4'd0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
